// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU and its issue arbiter: function codes,
// port count, default tag width, operand bundle and the grant-selection helper.
package alu_pkg;

  localparam int NUM_ALU_PORTS = 2;
  localparam int DEFAULT_TAG_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'd0,
    ALU_SLL     = 3'd1,
    ALU_SLT     = 3'd2,
    ALU_SLTU    = 3'd3,
    ALU_XOR     = 3'd4,
    ALU_SRL_SRA = 3'd5,
    ALU_OR      = 3'd6,
    ALU_AND_CLR = 3'd7
  } alu_func_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic        mod;
  } alu_op_t;

  // One-hot grant from the eligible set; a tie goes to port 0 under fixed
  // priority, otherwise to the port that did not win last time.
  function automatic logic [1:0] pick_grant(input logic [1:0] elig,
                                            input logic       last_grant,
                                            input logic       fixed_prio);
    case (elig)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return (fixed_prio || last_grant) ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Two-entry in-order response buffer; push and pop may share a cycle.
module alu_resp_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while
  // empty, so stale contents are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_issue_arbiter.sv
// Arbitrates two requesters onto one two-cycle ALU, tracks the in-flight op and
// returns each result with its tag through a per-port response FIFO.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int TAG_W         = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_a_p0,
  input  logic [31:0]      req_a_p1,
  input  logic [31:0]      req_b_p0,
  input  logic [31:0]      req_b_p1,
  input  logic [2:0]       req_func_p0,
  input  logic [2:0]       req_func_p1,
  input  logic             req_mod_p0,
  input  logic             req_mod_p1,
  input  logic [TAG_W-1:0] req_tag_p0,
  input  logic [TAG_W-1:0] req_tag_p1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_data_p0,
  output logic [31:0]      resp_data_p1,
  output logic [TAG_W-1:0] resp_tag_p0,
  output logic [TAG_W-1:0] resp_tag_p1,
  output logic [31:0]      alu_input_a,
  output logic [31:0]      alu_input_b,
  output logic [2:0]       alu_function_select,
  output logic             alu_function_modifier,
  input  logic [31:0]      alu_result
);

  localparam int W = 32 + TAG_W;

  alu_op_t          op   [NUM_ALU_PORTS];
  logic [TAG_W-1:0] tag  [NUM_ALU_PORTS];
  logic [1:0]       cnt  [NUM_ALU_PORTS];
  logic [W-1:0]     head [NUM_ALU_PORTS];

  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       resp_hs;
  logic [1:0]       fifo_full;
  logic [1:0]       fifo_empty;
  logic [1:0]       push_req;
  logic [1:0]       fifo_push;
  logic             last_grant;
  logic             ifl_valid;
  logic             ifl_port;
  logic [TAG_W-1:0] ifl_tag;

  assign op[0]  = '{a: req_a_p0, b: req_b_p0, func: req_func_p0, mod: req_mod_p0};
  assign op[1]  = '{a: req_a_p1, b: req_b_p1, func: req_func_p1, mod: req_mod_p1};
  assign tag[0] = req_tag_p0;
  assign tag[1] = req_tag_p1;

  assign resp_valid = ~fifo_empty;
  assign resp_hs    = resp_valid & resp_ready;

  // A popping port frees a credit in the same cycle, which is what lets a
  // single port with resp_ready high issue back to back.
  always_comb begin
    for (int p = 0; p < NUM_ALU_PORTS; p++) begin
      elig[p] = req_valid[p] && ((cnt[p] < 2'd2) || resp_hs[p]);
    end
  end

  // Grants are suppressed during reset so nothing is accepted and then lost.
  assign grant     = reset ? 2'b00 : pick_grant(elig, last_grant, PRIORITY_MODE == 1);
  assign req_ready = grant;

  always_comb begin
    alu_input_a           = '0;
    alu_input_b           = '0;
    alu_function_select   = '0;
    alu_function_modifier = 1'b0;
    for (int p = 0; p < NUM_ALU_PORTS; p++) begin
      if (grant[p]) begin
        alu_input_a           = op[p].a;
        alu_input_b           = op[p].b;
        alu_function_select   = op[p].func;
        alu_function_modifier = op[p].mod;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge value of its peers regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_ALU_PORTS; p++) cnt[p] <= 2'd0;
      last_grant <= 1'b1;
      ifl_valid  <= 1'b0;
      ifl_port   <= 1'b0;
      ifl_tag    <= '0;
    end else begin
      for (int p = 0; p < NUM_ALU_PORTS; p++) begin
        cnt[p] <= cnt[p] + {1'b0, grant[p]} - {1'b0, resp_hs[p]};
      end
      ifl_valid <= |grant;
      if (|grant) begin
        last_grant <= grant[1];
        ifl_port   <= grant[1];
        ifl_tag    <= grant[1] ? tag[1] : tag[0];
      end
    end
  end

  assign push_req  = ifl_valid ? (ifl_port ? 2'b10 : 2'b01) : 2'b00;
  assign fifo_push = push_req & ~fifo_full;

  for (genvar g = 0; g < NUM_ALU_PORTS; g++) begin : g_port
    alu_resp_fifo #(.W(W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push[g]),
      .push_data ({alu_result, ifl_tag}),
      .pop       (resp_hs[g]),
      .head_data (head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  assign resp_data_p0 = head[0][W-1:TAG_W];
  assign resp_data_p1 = head[1][W-1:TAG_W];
  assign resp_tag_p0  = head[0][TAG_W-1:0];
  assign resp_tag_p1  = head[1][TAG_W-1:0];

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: a round-robin and a fixed-priority instance share
// stimulus; each has its own two-cycle ALU model and queue-based reference.
module tb_alu_issue_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  resp_ready;
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];
  logic [2:0]  f_in [2];
  logic        m_in [2];
  logic [3:0]  t_in [2];

  logic [1:0]  rdy_o [2];
  logic [1:0]  rv_o  [2];
  logic [31:0] rd_o  [2][2];
  logic [3:0]  rt_o  [2][2];
  logic [31:0] aa_o  [2];
  logic [31:0] ab_o  [2];
  logic [2:0]  af_o  [2];
  logic        am_o  [2];
  logic [31:0] ares  [2];

  logic [31:0] xa [2];
  logic [31:0] xb [2];
  logic [2:0]  xf [2];
  logic        xm [2];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          avail;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  tag;
    int          cyc;
  } beat_t;

  exp_t  mq [4][$];
  beat_t rlog[$];
  int    ogl0[$];
  int    ogl1[$];
  int    last_m [2];
  int    cyc;
  int    total;
  int    bad;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.PRIORITY_MODE(0), .TAG_W(4)) dut_r (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_o[0]),
    .req_a_p0(a_in[0]), .req_a_p1(a_in[1]), .req_b_p0(b_in[0]), .req_b_p1(b_in[1]),
    .req_func_p0(f_in[0]), .req_func_p1(f_in[1]), .req_mod_p0(m_in[0]), .req_mod_p1(m_in[1]),
    .req_tag_p0(t_in[0]), .req_tag_p1(t_in[1]),
    .resp_valid(rv_o[0]), .resp_ready(resp_ready),
    .resp_data_p0(rd_o[0][0]), .resp_data_p1(rd_o[0][1]),
    .resp_tag_p0(rt_o[0][0]), .resp_tag_p1(rt_o[0][1]),
    .alu_input_a(aa_o[0]), .alu_input_b(ab_o[0]),
    .alu_function_select(af_o[0]), .alu_function_modifier(am_o[0]),
    .alu_result(ares[0])
  );

  alu_issue_arbiter #(.PRIORITY_MODE(1), .TAG_W(4)) dut_f (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_o[1]),
    .req_a_p0(a_in[0]), .req_a_p1(a_in[1]), .req_b_p0(b_in[0]), .req_b_p1(b_in[1]),
    .req_func_p0(f_in[0]), .req_func_p1(f_in[1]), .req_mod_p0(m_in[0]), .req_mod_p1(m_in[1]),
    .req_tag_p0(t_in[0]), .req_tag_p1(t_in[1]),
    .resp_valid(rv_o[1]), .resp_ready(resp_ready),
    .resp_data_p0(rd_o[1][0]), .resp_data_p1(rd_o[1][1]),
    .resp_tag_p0(rt_o[1][0]), .resp_tag_p1(rt_o[1][1]),
    .alu_input_a(aa_o[1]), .alu_input_b(ab_o[1]),
    .alu_function_select(af_o[1]), .alu_function_modifier(am_o[1]),
    .alu_result(ares[1])
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f, input logic m);
    case (f)
      3'd0:    return m ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return m ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return m ? (a & ~b) : (a & b);
    endcase
  endfunction

  // Two-cycle ALU stand-ins: inputs registered at the grant edge, result valid next cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      xa[k] <= aa_o[k];
      xb[k] <= ab_o[k];
      xf[k] <= af_o[k];
      xm[k] <= am_o[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) ares[k] = alu_fn(xa[k], xb[k], xf[k], xm[k]);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: compare against the reference at the falling edge, then advance it.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [1:0] rv_e;
      logic [1:0] pop_e;
      logic [1:0] el;
      logic [1:0] g;
      int         gp;
      for (int p = 0; p < 2; p++) begin
        rv_e[p]  = (mq[k*2+p].size() > 0) && (mq[k*2+p][0].avail <= cyc);
        pop_e[p] = rv_e[p] && resp_ready[p];
        el[p]    = req_valid[p] && ((mq[k*2+p].size() < 2) || pop_e[p]);
      end
      g = 2'b00;
      if (!reset) begin
        if (el == 2'b01)      g = 2'b01;
        else if (el == 2'b10) g = 2'b10;
        else if (el == 2'b11) g = ((k == 1) || (last_m[k] == 1)) ? 2'b01 : 2'b10;
      end
      gp = g[1] ? 1 : 0;
      check($sformatf("i%0d c%0d req_ready", k, cyc), rdy_o[k], g);
      check($sformatf("i%0d c%0d resp_valid", k, cyc), rv_o[k], rv_e);
      for (int p = 0; p < 2; p++) begin
        if (rv_e[p]) begin
          check($sformatf("i%0d c%0d p%0d data", k, cyc, p), rd_o[k][p], mq[k*2+p][0].data);
          check($sformatf("i%0d c%0d p%0d tag", k, cyc, p), rt_o[k][p], mq[k*2+p][0].tag);
        end
      end
      check($sformatf("i%0d c%0d alu_a", k, cyc), aa_o[k], (g != 0) ? a_in[gp] : 32'd0);
      check($sformatf("i%0d c%0d alu_b", k, cyc), ab_o[k], (g != 0) ? b_in[gp] : 32'd0);
      check($sformatf("i%0d c%0d alu_fm", k, cyc), {af_o[k], am_o[k]},
            (g != 0) ? {f_in[gp], m_in[gp]} : 4'd0);
      if (k == 0) begin
        ogl0.push_back(rdy_o[0] == 2'b01 ? 0 : rdy_o[0] == 2'b10 ? 1 : -1);
        check($sformatf("c%0d no_overflow_r", cyc), dut_r.push_req & dut_r.fifo_full, 2'b00);
        for (int p = 0; p < 2; p++) begin
          if (rv_o[0][p] && resp_ready[p] && !reset)
            rlog.push_back('{port: p, data: rd_o[0][p], tag: rt_o[0][p], cyc: cyc});
        end
      end else begin
        ogl1.push_back(rdy_o[1] == 2'b01 ? 0 : rdy_o[1] == 2'b10 ? 1 : -1);
        check($sformatf("c%0d no_overflow_f", cyc), dut_f.push_req & dut_f.fifo_full, 2'b00);
      end
      if (reset) begin
        mq[k*2].delete();
        mq[k*2+1].delete();
        last_m[k] = 1;
      end else begin
        for (int p = 0; p < 2; p++) if (pop_e[p]) void'(mq[k*2+p].pop_front());
        if (g != 0) begin
          mq[k*2+gp].push_back('{data: alu_fn(a_in[gp], b_in[gp], f_in[gp], m_in[gp]),
                                 tag: t_in[gp], avail: cyc + 2});
          last_m[k] = gp;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic m, input logic [3:0] t);
    a_in[p] = a; b_in[p] = b; f_in[p] = f; m_in[p] = m; t_in[p] = t;
  endtask

  task automatic rand_ops();
    for (int p = 0; p < 2; p++)
      set_op(p, $urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1)), 4'($urandom_range(15)));
  endtask

  initial begin
    int n;
    int cnt0;
    int n0;
    int n1;
    total = 0; bad = 0; cyc = 0;
    last_m[0] = 1; last_m[1] = 1;
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
    set_op(0, 0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    step();
    check("reset resp_valid", rv_o[0], 2'b00);
    check("reset req_ready", rdy_o[0], 2'b00);
    check("reset resp_data", {rd_o[0][0], rd_o[0][1]}, 64'd0);
    check("reset resp_tag", {rt_o[0][0], rt_o[0][1]}, 8'd0);
    check("reset alu_a", aa_o[0], 32'd0);

    // Basic ADD on port 0
    rlog.delete();
    set_op(0, 32'd5, 32'd7, 3'd0, 1'b0, 4'd3);
    req_valid = 2'b01;
    n = cyc;
    step();
    req_valid = 2'b00;
    repeat (4) step();
    check("add beats", rlog.size(), 1);
    if (rlog.size() > 0) begin
      check("add port", rlog[0].port, 0);
      check("add data", rlog[0].data, 32'd12);
      check("add tag", rlog[0].tag, 4'd3);
      check("add latency", rlog[0].cyc - n, 2);
    end

    // SUB on port 0, SRA on port 1
    rlog.delete();
    set_op(0, 32'd3, 32'd5, 3'd0, 1'b1, 4'd1);
    req_valid = 2'b01;
    step();
    set_op(1, 32'h8000_0000, 32'd4, 3'd5, 1'b1, 4'd2);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (4) step();
    check("subsra beats", rlog.size(), 2);
    if (rlog.size() == 2) begin
      check("sub port", rlog[0].port, 0);
      check("sub data", rlog[0].data, 32'hFFFF_FFFE);
      check("sub tag", rlog[0].tag, 4'd1);
      check("sra port", rlog[1].port, 1);
      check("sra data", rlog[1].data, 32'hF800_0000);
      check("sra tag", rlog[1].tag, 4'd2);
    end

    // Round-robin contention for 10 cycles
    rlog.delete(); ogl0.delete();
    n0 = 0; n1 = 8;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      t_in[0] = 4'(n0); t_in[1] = 4'(n1);
      step();
      if (ogl0[ogl0.size()-1] == 0) n0++;
      if (ogl0[ogl0.size()-1] == 1) n1++;
    end
    req_valid = 2'b00;
    repeat (4) step();
    for (int i = 0; i < 10; i++) check($sformatf("rr grant %0d", i), ogl0[i], i % 2);
    n0 = 0; n1 = 0;
    foreach (rlog[i]) begin
      if (rlog[i].port == 0) begin check($sformatf("rr p0 tag %0d", n0), rlog[i].tag, n0); n0++; end
      else begin check($sformatf("rr p1 tag %0d", n1), rlog[i].tag, 8 + n1); n1++; end
    end
    check("rr p0 beats", n0, 5);
    check("rr p1 beats", n1, 5);

    // Backpressure on port 0 while port 1 keeps issuing
    ogl0.delete();
    resp_ready = 2'b10;
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin rand_ops(); step(); end
    cnt0 = 0;
    foreach (ogl0[i]) if (ogl0[i] == 0) cnt0++;
    check("bp p0 grants", cnt0, 2);
    for (int i = 5; i < 8; i++) check($sformatf("bp stall %0d", i), ogl0[i], 1);
    resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin rand_ops(); step(); end
    cnt0 = 0;
    for (int i = 8; i < 14; i++) if (ogl0[i] == 0) cnt0++;
    check("bp p0 resumed", cnt0 > 0, 1'b1);

    // Reset one cycle after a grant
    req_valid = 2'b00;
    repeat (4) step();
    rand_ops();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-reset resp_valid %0d", i), rv_o[0], 2'b00);
    end
    ogl0.delete();
    req_valid = 2'b11;
    rand_ops();
    step();
    check("post-reset tie", ogl0[0], 0);
    req_valid = 2'b00;
    repeat (4) step();

    // Fixed priority instance under constant contention
    ogl1.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin rand_ops(); step(); end
    for (int i = 0; i < 8; i++) check($sformatf("fixed grant %0d", i), ogl1[i], 0);
    req_valid = 2'b00;
    repeat (4) step();

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req_valid = 2'($urandom);
      resp_ready = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      reset = ($urandom_range(99) == 0);
      step();
    end
    reset = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    repeat (6) step();
    check("drained", {rv_o[0], rv_o[1]}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

- Shares the single two-cycle integer ALU between two requesters (port 0: integer pipeline; port 1: address/auxiliary unit).
- Arbitrates valid/ready requests and drives the ALU operand and function inputs.
- Tracks the one in-flight operation and routes the ALU's second-cycle `result` into a per-port 2-entry response FIFO, returning it with the requester's tag.
- Sits between the issue stage and the ALU; the ALU is instantiated beside it at the same hierarchy level, not inside it.

## Interface
- `PRIORITY_MODE`, default 0: 0 = round-robin, 1 = fixed priority to port 0.
- `TAG_W`, default 4: width of the opaque requester tag.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port grant; a handshake occurs when valid and ready are both high.
- `req_a_p0`, `req_a_p1`, `req_b_p0`, `req_b_p1` in 32 each: operands.
- `req_func_p0`, `req_func_p1` in 3 each: ALU function code.
- `req_mod_p0`, `req_mod_p1` in 1 each: function modifier (SUB, SRA, CLR).
- `req_tag_p0`, `req_tag_p1` in TAG_W each: returned unchanged with the response.
- `resp_valid[1:0]` out 2; `resp_ready[1:0]` in 2: response handshake.
- `resp_data_p0`, `resp_data_p1` out 32; `resp_tag_p0`, `resp_tag_p1` out TAG_W.
- `alu_input_a`, `alu_input_b` out 32; `alu_function_select` out 3; `alu_function_modifier` out 1.
- `alu_result` in 32: the ALU's second-cycle result.

## Operation
- **Per-port credit counter `cnt[p]` (0..2).** It counts in-flight plus buffered responses.
  - Increments on a request handshake.
  - Decrements on a response handshake.
  - Both in the same cycle leaves it unchanged.
- **Eligibility:** `elig[p] = req_valid[p] && (cnt[p] < 2 || (resp_valid[p] && resp_ready[p]))`.
- **Arbitration is combinational, at most one grant per cycle.**
  - Only one port eligible: that port is granted.
  - Both eligible with PRIORITY_MODE=0: grant the port that is not `last_grant`.
  - Both eligible with PRIORITY_MODE=1: grant port 0.
  - `last_grant` updates only on a grant.
- **ALU drive:**
  - Granted cycle: the ALU outputs carry the granted port's a, b, func and mod combinationally.
  - No grant: all ALU outputs are 0 (ADD of zeros). This is harmless because results are tracked by tag, not by ALU state.
- **In-flight register** (`ifl_valid`, `ifl_port`, `ifl_tag`): loaded at the end of the grant cycle. `ifl_valid` is 0 when there is no grant.
- **Capture:** in the cycle with `ifl_valid=1`, `{alu_result, ifl_tag}` is pushed into FIFO[`ifl_port`] at the clock edge.
- **Response FIFO per port:** 2 entries, in order.
  - `resp_valid` = not empty; data and tag come from the head.
  - Push and pop may occur in the same cycle.
  - Overflow is impossible by construction, and the bench asserts it.
- **Ordering:** responses per port are returned in issue order. No ordering is guaranteed between the two ports.
- **Reset:**
  - Clears `cnt`, FIFOs, `ifl_valid`; sets `last_grant`=1 so port 0 wins the first tie.
  - Reset mid-operation discards in-flight and buffered results.
  - No `resp_valid` appears after reset until a new grant; the ALU's unreset registers are never observed.

## Timing
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_tag`=0, all ALU outputs 0.
- **Latency:** grant in cycle N; ALU samples at the end of N; `alu_result` is valid during N+1; it is pushed at the end of N+1; `resp_valid` rises in N+2. Minimum latency is 2 cycles.
- **Throughput:**
  - One issue per cycle in total.
  - A single port with `resp_ready` held high sustains one request per cycle, because credit 2 covers in-flight plus head.
- **`req_ready` dependencies:** it may depend combinationally on `req_valid` and `resp_ready`. `resp_valid` never depends combinationally on any input.
- **Stalls:**
  - `req_ready[p]`=0 while `cnt[p]`==2 and port p is not popping.
  - Stalling one port's responses never blocks the other port.

## Structure
- **Shared package `alu_pkg`:**
  - Function codes ALU_ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND_CLR=7.
  - `NUM_ALU_PORTS`=2.
  - Default `TAG_W`.
- **Sub-module `alu_resp_fifo`:** a 2-entry synchronous FIFO of width 32+TAG_W with push/pop/full/empty, instantiated once per port.
- **Top level:** the arbiter, credit counters and in-flight register stay in `alu_issue_arbiter`.

## Test plan
- **Basic ADD:** port 0 issues ADD a=5, b=7, tag=3 in N, `resp_ready`=1 → `req_ready[0]`=1 in N; `resp_valid[0]` in N+2 with data 12, tag 3; exactly one beat.
- **SUB and SRA:** SUB 3−5 → 0xFFFFFFFE. SRA a=0x80000000, b=4 (mod=1) → 0xF8000000. Each response arrives on the issuing port only.
- **Round-robin contention:** both ports valid every cycle for 10 cycles (PRIORITY_MODE=0) → grants alternate 0,1,0,1 starting with 0. Each port receives 5 in-order responses with matching tags.
- **Backpressure:** `resp_ready[0]`=0 with port 0 issuing continuously → 2 grants, then `req_ready[0]`=0 while port 1 takes every cycle. Release `resp_ready[0]` → both buffered responses drain in order, then port 0 resumes.
- **Reset mid-operation:** `reset` asserted in N+1 after a grant in N → no `resp_valid` in N+2 or later, `cnt`=0, next tie is granted to port 0.
- **Fixed priority:** PRIORITY_MODE=1, both ports valid with responses always accepted → port 0 is granted every cycle and port 1 never is.
